alu_share_ctrl: RTL and testbench

- Controller that time-shares one combinational EX-stage ALU instance between two requesters: req0 (main pipeline EX) and req1 (multi-cycle helper unit).
- Arbitrates round-robin, registers the granted operation, and drives the ALU operand, command and carry/overflow-in ports.
- Captures the ALU result into a one-entry response buffer per requester.
- Owns the architectural status register {N,Z,C,V}, which supplies the ALU carry-in and overflow-in.

---
 rtl/alu_share_ctrl_if.sv | 44 ++++
 rtl/alu_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester, response and ALU-side signals of the shared-ALU controller.
// slave = the controller; master = requesters, response consumers and the ALU itself.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid, req0_ready, req0_s;
    logic [WIDTH-1:0] req0_in1, req0_in2;
    logic [3:0]       req0_cmd;
    logic             req1_valid, req1_ready, req1_s;
    logic [WIDTH-1:0] req1_in1, req1_in2;
    logic [3:0]       req1_cmd;

    logic             rsp0_valid, rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic [3:0]       rsp0_sr;
    logic             rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic [3:0]       rsp1_sr;

    logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
    logic [3:0]       alu_cmd, alu_sr;
    logic             alu_cin, alu_vin;
    logic [3:0]       sr;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_cmd, req0_s,
        input  req1_valid, req1_in1, req1_in2, req1_cmd, req1_s,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_sr, rsp1_valid, rsp1_result, rsp1_sr,
        input  rsp0_ready, rsp1_ready,
        output alu_in1, alu_in2, alu_cmd, alu_cin, alu_vin, sr,
        input  alu_result, alu_sr
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_cmd, req0_s,
        output req1_valid, req1_in1, req1_in2, req1_cmd, req1_s,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_sr, rsp1_valid, rsp1_result, rsp1_sr,
        output rsp0_ready, rsp1_ready,
        input  alu_in1, alu_in2, alu_cmd, alu_cin, alu_vin, sr,
        output alu_result, alu_sr
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one combinational EX-stage ALU between req0 (pipeline EX)
// and req1 (helper unit). Round-robin grant into a single op slot, one response buffer
// per requester, and ownership of the architectural {N,Z,C,V} status register.
// Optional: `define ALU_SHARE_STATS_EN adds saturating per-requester stall counters.
module alu_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_ctrl_if.slave bus
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [15:0]     stall0_cnt,
    output logic [15:0]     stall1_cnt
`endif
);
    localparam int NREQ = 2;

    typedef struct packed {
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic [3:0]       cmd;
        logic             s;
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       sr;
    } rsp_t;

    op_t  [NREQ-1:0] req_op;
    rsp_t [NREQ-1:0] rsp_data;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;

    logic       op_valid;
    op_t        op_q;
    logic       op_owner;
    logic       last_grant;
    logic [3:0] sr_q;

    logic complete, can_accept, grant, accept;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_op[0] = {bus.req0_in1, bus.req0_in2, bus.req0_cmd, bus.req0_s};
    assign req_op[1] = {bus.req1_in1, bus.req1_in2, bus.req1_cmd, bus.req1_s};

    // Slot retires when its owner's buffer is free or draining; a retiring slot can refill
    // at the same edge. Contention goes to whoever was not granted last.
    always_comb begin
        complete   = op_valid & (~rsp_valid[op_owner] | rsp_ready[op_owner]);
        can_accept = ~op_valid | complete;
        grant      = (&req_valid) ? ~last_grant : req_valid[1];
        req_ready  = '0;
        // Ready is held low while reset is asserted so no handshake is signalled then.
        if (rst && can_accept && req_valid[grant])
            req_ready[grant] = 1'b1;
        accept = |req_ready;
    end

    // Op slot: load on handshake, empty on retire, otherwise hold so ALU inputs stay stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid   <= 1'b0;
            op_q       <= '0;
            op_owner   <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_valid   <= 1'b1;
            op_q       <= req_op[grant];
            op_owner   <= grant;
            last_grant <= grant;
        end else if (complete) begin
            op_valid   <= 1'b0;
        end
    end

    // Status register takes the ALU flags of a retiring op that asked for it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sr_q <= 4'b0000;
        else if (complete && op_q.s)
            sr_q <= bus.alu_sr;
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        logic v_q;
        rsp_t d_q;
        logic cap;

        assign cap = complete & (op_owner == 1'(g));

        // Response buffer: capture wins over drain, so capture+drain keeps valid high
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (cap) begin
                v_q <= 1'b1;
                d_q <= {bus.alu_result, bus.alu_sr};
            end else if (rsp_ready[g]) begin
                v_q <= 1'b0;
            end
        end

        assign rsp_valid[g] = v_q;
        assign rsp_data[g]  = d_q;
    end

`ifdef ALU_SHARE_STATS_EN
    logic [NREQ-1:0][15:0] stall_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [15:0] cnt_q;

        // Count cycles a requester waits with a valid op, holding at the ceiling
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt_q <= '0;
            else if (req_valid[g] && !req_ready[g] && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end

        assign stall_cnt[g] = cnt_q;
    end

    assign stall0_cnt = stall_cnt[0];
    assign stall1_cnt = stall_cnt[1];
`endif

    assign bus.req0_ready  = req_ready[0];
    assign bus.req1_ready  = req_ready[1];
    assign bus.rsp0_valid  = rsp_valid[0];
    assign bus.rsp0_result = rsp_data[0].result;
    assign bus.rsp0_sr     = rsp_data[0].sr;
    assign bus.rsp1_valid  = rsp_valid[1];
    assign bus.rsp1_result = rsp_data[1].result;
    assign bus.rsp1_sr     = rsp_data[1].sr;

    assign bus.alu_in1 = op_valid ? op_q.in1 : '0;
    assign bus.alu_in2 = op_valid ? op_q.in2 : '0;
    assign bus.alu_cmd = op_valid ? op_q.cmd : 4'h0;
    assign bus.alu_cin = sr_q[1];
    assign bus.alu_vin = sr_q[0];
    assign bus.sr      = sr_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed scenarios plus randomized traffic for alu_share_ctrl.
// The bench owns the ALU (MOV=1, ADD=2, ADC=3, anything else yields 0) and keeps a
// transaction-level reference: a queue of accepted-but-unretired ops and one queue of
// pending responses per requester. Define ALU_SHARE_STATS_EN to also check the counters.
module tb_alu_share_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.WIDTH(32)) bus ();

`ifdef ALU_SHARE_STATS_EN
    logic [15:0] stall0_cnt, stall1_cnt;
`endif

    alu_share_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef ALU_SHARE_STATS_EN
        ,
        .stall0_cnt (stall0_cnt),
        .stall1_cnt (stall1_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Returns {result, N, Z, C, V}
    function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] cmd, logic cin);
        logic [32:0] t;
        logic [31:0] r;
        logic        v;
        case (cmd)
            4'h1:    t = {1'b0, b};
            4'h2:    t = {1'b0, a} + {1'b0, b};
            4'h3:    t = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            default: t = '0;
        endcase
        r = t[31:0];
        v = (cmd == 4'h2 || cmd == 4'h3) && (a[31] == b[31]) && (r[31] != a[31]);
        return {r, r[31], r == 32'd0, t[32], v};
    endfunction

    assign {bus.alu_result, bus.alu_sr} = alu_f(bus.alu_in1, bus.alu_in2, bus.alu_cmd, bus.alu_cin);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        owner;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  cmd;
        logic        s;
    } op_rec_t;

    op_rec_t     inflight[$];
    logic [35:0] held0[$];
    logic [35:0] held1[$];
    logic [3:0]  m_sr;
    logic        m_last;
    int          st0, st1;

    task automatic model_cycle();
        logic        v0, v1, rr0, rr1, retire, room, who, e0, e1, own;
        op_rec_t     f;
        logic [35:0] res;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        rr0 = bus.rsp0_ready; rr1 = bus.rsp1_ready;
        f = '0;
        res = '0;

        chk("rsp0_valid", bus.rsp0_valid, held0.size() != 0);
        chk("rsp1_valid", bus.rsp1_valid, held1.size() != 0);
        if (held0.size() != 0) chk("rsp0_data", {bus.rsp0_result, bus.rsp0_sr}, held0[0]);
        if (held1.size() != 0) chk("rsp1_data", {bus.rsp1_result, bus.rsp1_sr}, held1[0]);
        chk("sr", bus.sr, m_sr);
        chk("alu_cin", bus.alu_cin, m_sr[1]);
        chk("alu_vin", bus.alu_vin, m_sr[0]);
        if (inflight.size() != 0) begin
            chk("alu_in1", bus.alu_in1, inflight[0].in1);
            chk("alu_in2", bus.alu_in2, inflight[0].in2);
            chk("alu_cmd", bus.alu_cmd, inflight[0].cmd);
        end else begin
            chk("alu_idle", {bus.alu_in1, bus.alu_in2, bus.alu_cmd}, 68'd0);
        end

        // An op leaves the ALU once its requester has room for the answer.
        retire = 1'b0;
        if (inflight.size() != 0) begin
            own = inflight[0].owner;
            retire = own ? (held1.size() == 0 || rr1) : (held0.size() == 0 || rr0);
        end
        room = (inflight.size() == 0) || retire;
        who  = (v0 && v1) ? ~m_last : v1;
        e0   = room && v0 && !who;
        e1   = room && v1 && who;
        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
`ifdef ALU_SHARE_STATS_EN
        chk("stall0_cnt", stall0_cnt, st0);
        chk("stall1_cnt", stall1_cnt, st1);
        if (v0 && !e0 && st0 < 65535) st0++;
        if (v1 && !e1 && st1 < 65535) st1++;
`endif

        // What the coming edge does
        if (retire) begin
            f = inflight.pop_front();
            res = alu_f(f.in1, f.in2, f.cmd, m_sr[1]);
        end
        if (rr0 && held0.size() != 0) held0.delete(0);
        if (rr1 && held1.size() != 0) held1.delete(0);
        if (retire) begin
            if (f.owner) held1.push_back(res); else held0.push_back(res);
            if (f.s) m_sr = res[3:0];
        end
        if (e0) inflight.push_back({1'b0, bus.req0_in1, bus.req0_in2, bus.req0_cmd, bus.req0_s});
        if (e1) inflight.push_back({1'b1, bus.req1_in1, bus.req1_in2, bus.req1_cmd, bus.req1_s});
        if (e0 || e1) m_last = who;
    endtask

    task automatic model_reset();
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk("rst_sr", bus.sr, 4'b0000);
        chk("rst_alu", {bus.alu_in1, bus.alu_in2, bus.alu_cmd}, 68'd0);
`ifdef ALU_SHARE_STATS_EN
        chk("rst_stall_cnt", {stall0_cnt, stall1_cnt}, 32'd0);
`endif
        inflight.delete(); held0.delete(); held1.delete();
        m_sr = 4'b0000; m_last = 1'b1; st0 = 0; st1 = 0;
    endtask

    // Compare process: inputs change on the falling edge, outputs are judged 2ns later.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) model_reset();
        else      model_cycle();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic s);
        bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_cmd = c; bus.req0_s = s;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic s);
        bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_cmd = c; bus.req1_s = s;
    endtask

    task automatic idle();
        set0(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
        set1(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        tick(); idle(); #3 rst = 1'b0;
        tick(); tick(); #3 rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_cmd();
        case ($urandom_range(0, 5))
            0:       return 4'h1;
            1:       return 4'h2;
            2, 3:    return 4'h3;
            default: return 4'($urandom_range(4, 15));
        endcase
    endfunction

    initial begin
        idle();
        // Reset: a valid request must not see ready while reset is held.
        tick(); set0(1'b1, 32'd1, 32'd2, 4'h2, 1'b0);
        #3 chk("lit_rst_ready0", bus.req0_ready, 1'b0);
        chk("lit_rst_sr", bus.sr, 4'b0000);
        tick(); idle(); #3 rst = 1'b1;

        // Contention from reset: grants 0,1,0,1; each response returns its in2.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                set0(1'b1, 32'd0, 32'(100 + i), 4'h1, 1'b0);
                set1(1'b1, 32'd0, 32'(200 + i), 4'h1, 1'b0);
            end else idle();
            #3;
            if (i < 4) chk("lit_alt_ready0", bus.req0_ready, (i % 2) == 0);
            if (i >= 2) begin
                if ((i % 2) == 0) chk("lit_alt_rsp0", {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 32'(98 + i)});
                else              chk("lit_alt_rsp1", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 32'(198 + i)});
            end
        end

        // ADD 5+7 with s=1: result two cycles after accept, flags all clear.
        tick(); set0(1'b1, 32'd5, 32'd7, 4'h2, 1'b1);
        #3 chk("lit_add_ready", bus.req0_ready, 1'b1);
        tick(); idle();
        tick(); #3 chk("lit_add_rsp", {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_sr}, {1'b1, 32'd12, 4'b0000});
        chk("lit_add_sr", bus.sr, 4'b0000);

        // Carry chain: ADD FFFFFFFF+1 (s=1) then ADC 0+0 sees C=1.
        tick(); set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'h2, 1'b1);
        tick(); set0(1'b1, 32'd0, 32'd0, 4'h3, 1'b0);
        tick(); idle();
        #3 chk("lit_carry_cin", bus.alu_cin, 1'b1);
        chk("lit_carry_rsp", {bus.rsp0_result, bus.rsp0_sr}, {32'd0, 4'b0110});
        chk("lit_carry_sr", bus.sr, 4'b0110);
        tick(); #3 chk("lit_adc_rsp", bus.rsp0_result, 32'd1);

        // Stall: rsp1 full and not drained, second req1 op stuck in slot.
        do_reset();
        tick(); set1(1'b1, 32'd0, 32'hAAAA, 4'h1, 1'b0); bus.rsp1_ready = 1'b0;
        #3 chk("lit_stall_acc0", bus.req1_ready, 1'b1);
        tick(); set1(1'b1, 32'd0, 32'hBBBB, 4'h1, 1'b0);
        #3 chk("lit_stall_acc1", bus.req1_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            set1(1'b1, 32'd0, 32'hCCCC, 4'h1, 1'b0);
            set0(1'b1, 32'd0, 32'hDDDD, 4'h1, 1'b0);
            #3 chk("lit_stall_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
            chk("lit_stall_rsp1", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 32'hAAAA});
            chk("lit_stall_in2", bus.alu_in2, 32'hBBBB);
        end
        tick(); idle();
        #3 chk("lit_stall_hold", bus.rsp1_result, 32'hAAAA);
`ifdef ALU_SHARE_STATS_EN
        chk("lit_stall1_cnt", stall1_cnt, 16'd5);
        chk("lit_stall0_cnt", stall0_cnt, 16'd5);
`endif
        tick(); #3 chk("lit_stall_release", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 32'hBBBB});

        // Reset with an op in the slot and a full buffer.
        tick(); set0(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 1'b1); bus.rsp0_ready = 1'b0;
        tick(); set0(1'b1, 32'd1, 32'd1, 4'h2, 1'b1);
        #3 chk("lit_mid_ready", bus.req0_ready, 1'b1);
        tick(); set0(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
        #3 chk("lit_mid_sr", bus.sr, 4'b1010);
        chk("lit_mid_full", bus.rsp0_valid, 1'b1);
        rst = 1'b0;
        #1 chk("lit_mid_valids", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        chk("lit_mid_sr_clr", bus.sr, 4'b0000);
        chk("lit_mid_alu", bus.alu_in1, 32'd0);
        tick(); idle();
        tick(); #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #3 chk("lit_mid_norsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            set0($urandom_range(0, 99) < 60, rnd_opnd(), rnd_opnd(), rnd_cmd(), 1'($urandom_range(0, 1)));
            set1($urandom_range(0, 99) < 50, rnd_opnd(), rnd_opnd(), rnd_cmd(), 1'($urandom_range(0, 1)));
            bus.rsp0_ready = $urandom_range(0, 99) < 70;
            bus.rsp1_ready = $urandom_range(0, 99) < 60;
        end
        tick(); idle();
        tick(); tick(); #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
